trdb_stream_arbiter: RTL and testbench

TRDB_STREAM_ARBITER -- requirements
Module: trdb_stream_arbiter

---
 rtl/trdb_pkg.sv | 19 +
 rtl/trdb_rr_arbiter.sv | 33 +++
 rtl/trdb_stream_arbiter.sv | 129 ++++++++++++
 tb/tb_trdb_stream_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trdb_pkg.sv
// Shared types and default sizing for the trace stream arbiter.
package trdb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } trdb_arb_state_t;

    localparam int unsigned TRDB_NUM_SRC   = 4;
    localparam int unsigned TRDB_BURST_MAX = 8;
    localparam int unsigned TRDB_XLEN      = 32;

    // Index width for n sources, never narrower than one bit.
    function automatic int unsigned trdb_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trdb_rr_arbiter.sv
// Combinational round-robin picker: first request after the last grant, wrapping,
// with the last grant itself searched last.
module trdb_rr_arbiter
    import trdb_pkg::*;
#(
    parameter  int unsigned NUM_SRC = TRDB_NUM_SRC,
    localparam int unsigned IW      = trdb_idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [IW-1:0]      winner,
    output logic               any
);

    int unsigned idx;
    logic        found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            idx = (32'(last) + k) % NUM_SRC;
            if (!found && req[IW'(idx)]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/trdb_stream_arbiter.sv
// Merges several trace encoder word streams into one sink, granting each source
// a burst of up to BURST_MAX words in round-robin order.
module trdb_stream_arbiter
    import trdb_pkg::*;
#(
    parameter  int unsigned NUM_SRC   = TRDB_NUM_SRC,
    parameter  int unsigned BURST_MAX = TRDB_BURST_MAX,
    parameter  int unsigned XLEN      = TRDB_XLEN,
    localparam int unsigned IW        = trdb_idx_w(NUM_SRC)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic [NUM_SRC-1:0]            src_valid_i,
    input  logic [NUM_SRC-1:0][XLEN-1:0]  src_word_i,
    output logic [NUM_SRC-1:0]            src_ready_o,
    output logic [XLEN-1:0]               word_o,
    output logic [IW-1:0]                 src_id_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          idle_o
);

    localparam int unsigned CW = $clog2(BURST_MAX + 1);

    trdb_arb_state_t state_q, state_d;
    logic [IW-1:0]   cur_src_q, cur_src_d;
    logic [IW-1:0]   last_src_q, last_src_d;
    logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [XLEN-1:0] word_d;
    logic [IW-1:0]   src_id_d;
    logic            valid_d;

    logic            slot_free;
    logic            grant_ok;
    logic            xfer;
    logic            burst_last;
    logic [IW-1:0]   rr_winner;
    logic            rr_any;

    trdb_rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_rr (
        .req    (src_valid_i),
        .last   (last_src_q),
        .winner (rr_winner),
        .any    (rr_any)
    );

    assign slot_free  = !valid_o || ready_i;
    assign grant_ok   = (state_q == BURST) && enable_i && slot_free;
    assign xfer       = grant_ok && src_valid_i[cur_src_q];
    assign burst_last = (burst_cnt_q == CW'(BURST_MAX - 1));
    assign idle_o     = (state_q == IDLE) && !valid_o;

    // Only the granted source sees ready; reset masks it immediately.
    always_comb begin
        src_ready_o = '0;
        if (grant_ok && !rst_i) begin
            src_ready_o[cur_src_q] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_src_d   = cur_src_q;
        last_src_d  = last_src_q;
        burst_cnt_d = burst_cnt_q;
        word_d      = word_o;
        src_id_d    = src_id_o;
        valid_d     = valid_o;

        if (xfer) begin
            word_d      = src_word_i[cur_src_q];
            src_id_d    = cur_src_q;
            valid_d     = 1'b1;
            burst_cnt_d = burst_cnt_q + CW'(1);
        end else if (ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (enable_i && rr_any) begin
                    cur_src_d   = rr_winner;
                    burst_cnt_d = '0;
                    state_d     = BURST;
                end
            end
            BURST: begin
                if (!enable_i) begin
                    state_d    = DRAIN;
                    last_src_d = cur_src_q;
                end else if (!src_valid_i[cur_src_q] || (xfer && burst_last)) begin
                    state_d    = IDLE;
                    last_src_d = cur_src_q;
                end
            end
            DRAIN: begin
                if (!valid_o || ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_src resets to the top index so the first search starts at source 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cur_src_q   <= '0;
            last_src_q  <= IW'(NUM_SRC - 1);
            burst_cnt_q <= '0;
            word_o      <= '0;
            src_id_o    <= '0;
            valid_o     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_src_q   <= cur_src_d;
            last_src_q  <= last_src_d;
            burst_cnt_q <= burst_cnt_d;
            word_o      <= word_d;
            src_id_o    <= src_id_d;
            valid_o     <= valid_d;
        end
    end

endmodule

// File: tb/tb_trdb_stream_arbiter.sv
// Directed bench for trdb_stream_arbiter; sources emit {id, sequence} words.
module tb_trdb_stream_arbiter;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [3:0]       src_valid;
    logic [3:0][31:0] src_word;
    logic [3:0]       src_ready;
    logic [31:0]      word_o;
    logic [1:0]       src_id_o;
    logic             valid_o;
    logic             ready;
    logic             idle_o;

    int checks = 0;
    int errors = 0;
    int budget [4];
    int taken  [4];
    int base   [4];
    int n, early, gap;
    bit seen;

    trdb_stream_arbiter #(
        .NUM_SRC   (4),
        .BURST_MAX (8),
        .XLEN      (32)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .src_valid_i (src_valid),
        .src_word_i  (src_word),
        .src_ready_o (src_ready),
        .word_o      (word_o),
        .src_id_o    (src_id_o),
        .valid_o     (valid_o),
        .ready_i     (ready),
        .idle_o      (idle_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] wexp(input int id, input int sq);
        return {8'(id), 24'(sq)};
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            src_valid[i] = budget[i] > taken[i];
            src_word[i]  = wexp(i, taken[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (src_valid[i] && src_ready[i]) taken[i] <= taken[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 4; i++) budget[i] = taken[i];
        rst    = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        enable = 1'b1;
        ready  = 1'b1;
        for (int i = 0; i < 4; i++) base[i] = taken[i];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            budget[i] = 0;
            base[i]   = 0;
        end
        repeat (2) @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_idle", idle_o, 1);
        check("rst_word", word_o, 0);
        check("rst_id", src_id_o, 0);
        check("rst_ready", src_ready, 0);

        // Single source, 10 words: burst of 8, bubble, burst of 2.
        do_reset();
        budget[2] = taken[2] + 10;
        for (int s = 1; s <= 14; s++) begin
            @(negedge clk);
            if (s == 1) begin
                check("A_v1", valid_o, 0);
                check("A_rdy1", src_ready, 4'b0100);
            end else if (s <= 9) begin
                check("A_v", valid_o, 1);
                check("A_word", word_o, wexp(2, base[2] + s - 2));
                check("A_id", src_id_o, 2);
            end else if (s == 10) begin
                check("A_bubble", valid_o, 0);
            end else if (s <= 12) begin
                check("A_word2", word_o, wexp(2, base[2] + s - 3));
                check("A_v2", valid_o, 1);
            end else begin
                check("A_end_v", valid_o, 0);
                check("A_end_idle", idle_o, 1);
            end
        end

        // All sources busy: grant order 0,1,2,3,0 with 8 words each.
        do_reset();
        for (int i = 0; i < 4; i++) budget[i] = taken[i] + 100;
        n = 0;
        for (int s = 0; s < 200 && n < 40; s++) begin
            @(negedge clk);
            if (valid_o && ready) begin
                check("B_id", src_id_o, (n / 8) % 4);
                check("B_word", word_o, wexp((n / 8) % 4, base[(n / 8) % 4] + n % 8 + 8 * (n / 32)));
                n++;
            end
        end
        check("B_count", n, 40);

        // Sources 1 and 3 from reset: 1, then 3, then 1 again after wrap.
        do_reset();
        budget[1] = taken[1] + 10;
        budget[3] = taken[3] + 4;
        n = 0;
        for (int s = 0; s < 100 && n < 14; s++) begin
            @(negedge clk);
            if (valid_o && ready) begin
                if (n < 8) begin
                    check("C_id", src_id_o, 1);
                    check("C_word", word_o, wexp(1, base[1] + n));
                end else if (n < 12) begin
                    check("C_id", src_id_o, 3);
                    check("C_word", word_o, wexp(3, base[3] + n - 8));
                end else begin
                    check("C_id", src_id_o, 1);
                    check("C_word", word_o, wexp(1, base[1] + n - 4));
                end
                n++;
            end
        end
        check("C_count", n, 14);

        // Sink stall for 5 cycles mid-burst.
        do_reset();
        budget[0] = taken[0] + 20;
        n = 0;
        for (int s = 0; s < 50 && n < 3; s++) begin
            @(negedge clk);
            if (valid_o) begin
                check("D_word", word_o, wexp(0, base[0] + n));
                n++;
            end
        end
        check("D_pre", n, 3);
        @(negedge clk);
        ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("D_hold_v", valid_o, 1);
            check("D_hold_w", word_o, wexp(0, base[0] + 3));
            check("D_hold_id", src_id_o, 0);
            check("D_hold_rdy", src_ready, 0);
        end
        ready = 1'b1;
        n = 4;
        early = 0;
        gap = 0;
        for (int s = 0; s < 40 && n < 9; s++) begin
            @(negedge clk);
            if (valid_o) begin
                check("D_word", word_o, wexp(0, base[0] + n));
                n++;
            end else if (n < 8) begin
                early++;
            end else begin
                gap++;
            end
        end
        check("D_count", n, 9);
        check("D_early_gap", early, 0);
        check("D_bubble", gap, 1);

        // Enable dropped mid-burst with the sink stalled: drain, then idle.
        do_reset();
        budget[1] = taken[1] + 20;
        n = 0;
        for (int s = 0; s < 50 && n < 2; s++) begin
            @(negedge clk);
            if (valid_o && ready) n++;
        end
        check("E_pre", n, 2);
        @(negedge clk);
        check("E_word", word_o, wexp(1, base[1] + 2));
        enable = 1'b0;
        ready  = 1'b0;
        #1;
        check("E_rdy_off", src_ready, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("E_drain_v", valid_o, 1);
            check("E_drain_w", word_o, wexp(1, base[1] + 2));
            check("E_drain_rdy", src_ready, 0);
            check("E_drain_idle", idle_o, 0);
        end
        ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("E_idle", idle_o, 1);
            check("E_idle_v", valid_o, 0);
            check("E_idle_rdy", src_ready, 0);
        end
        enable = 1'b1;
        seen = 1'b0;
        for (int s = 0; s < 10 && !seen; s++) begin
            @(negedge clk);
            if (valid_o) begin
                seen = 1'b1;
                check("E_resume_id", src_id_o, 1);
                check("E_resume_w", word_o, wexp(1, base[1] + 3));
            end
        end
        check("E_resume_seen", seen, 1);

        // Reset during a live burst discards the output and restarts at source 1.
        do_reset();
        budget[1] = taken[1] + 40;
        budget[3] = taken[3] + 40;
        seen = 1'b0;
        for (int s = 0; s < 40 && !seen; s++) begin
            @(negedge clk);
            if (valid_o && src_id_o == 2'd3) seen = 1'b1;
        end
        check("F_src3_seen", seen, 1);
        rst = 1'b1;
        #1;
        check("F_rdy_rst", src_ready, 0);
        @(negedge clk);
        check("F_v", valid_o, 0);
        check("F_idle", idle_o, 1);
        check("F_word", word_o, 0);
        rst = 1'b0;
        seen = 1'b0;
        for (int s = 0; s < 10 && !seen; s++) begin
            @(negedge clk);
            if (valid_o) begin
                seen = 1'b1;
                check("F_next_id", src_id_o, 1);
                check("F_next_w", word_o, wexp(1, base[1] + 8));
            end
        end
        check("F_next_seen", seen, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
